// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the cache geometry, the widths derived from it, the controller
// state encoding, the line-store write operations and a line-address helper.
package dcache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int LINES          = 4;
    localparam int WORDS_PER_LINE = 4;

    localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;
    localparam int LINE_W   = WORD_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVICT = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

    // Operations accepted by the single write port of the line store.
    typedef enum logic [1:0] {
        WR_NONE  = 2'd0,
        WR_WORD  = 2'd1,   // store one word, mark line dirty
        WR_LINE  = 2'd2,   // install refilled line, tag, valid, clean
        WR_CLEAN = 2'd3    // victim written back, clear dirty
    } wr_op_e;

    // Line-aligned byte address built from a tag and an index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx);
        return {tag, idx, {(OFFSET_W + 2){1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Bundle of the pipeline request/response signals and the main-memory
// line transaction signals of the data cache.
//   master : the environment (pipeline + memory); drives requests, refill data, acks
//   slave  : the cache controller; drives load data, stalls and memory requests
interface dcache_if;
    import dcache_pkg::*;

    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [WORD_W-1:0]     req_wdata;
    logic [WORD_W-1:0]     rdata;
    logic                  d_cache_miss;
    logic                  enable_write_from_cache_to_memory;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [LINE_W-1:0]     mem_wline;
    logic [LINE_W-1:0]     mem_rline;
    logic                  mem_ack;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rline, mem_ack,
        input  rdata, d_cache_miss, enable_write_from_cache_to_memory,
               mem_req, mem_we, mem_addr, mem_wline
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rline, mem_ack,
        output rdata, d_cache_miss, enable_write_from_cache_to_memory,
               mem_req, mem_we, mem_addr, mem_wline
    );

endinterface

// File: rtl/dcache_line_store.sv
// Tag, data, valid and dirty storage of the cache.
//   clk, reset      : clock, asynchronous active-low clear of valid/dirty
//   rd_index        : combinational read port -> rd_tag, rd_line, rd_valid, rd_dirty
//   wr_op/wr_index  : single write port; word store, line install or dirty clear
//   wr_offset/word  : word store position and data
//   wr_line/wr_tag  : refilled line and its tag
// Tag and data arrays carry no reset; only valid/dirty define cache state.
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_line,
    output logic                rd_valid,
    output logic                rd_dirty,
    input  wr_op_e              wr_op,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [WORD_W-1:0]   wr_word,
    input  logic [LINE_W-1:0]   wr_line,
    input  logic [TAG_W-1:0]    wr_tag
);

    logic [TAG_W-1:0]  tag_r   [LINES];
    logic [LINE_W-1:0] data_r  [LINES];
    logic [LINES-1:0]  valid_r;
    logic [LINES-1:0]  dirty_r;

    // Data and tag array updates (no reset).
    always_ff @(posedge clk) begin
        case (wr_op)
            WR_WORD: data_r[wr_index][int'(wr_offset) * WORD_W +: WORD_W] <= wr_word;
            WR_LINE: begin
                data_r[wr_index] <= wr_line;
                tag_r[wr_index]  <= wr_tag;
            end
            default: ;
        endcase
    end

    // Valid and dirty bits, cleared asynchronously so a reset invalidates everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= {LINES{1'b0}};
            dirty_r <= {LINES{1'b0}};
        end else begin
            case (wr_op)
                WR_WORD:  dirty_r[wr_index] <= 1'b1;
                WR_LINE: begin
                    valid_r[wr_index] <= 1'b1;
                    dirty_r[wr_index] <= 1'b0;
                end
                WR_CLEAN: dirty_r[wr_index] <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rd_tag   = tag_r[rd_index];
    assign rd_line  = data_r[rd_index];
    assign rd_valid = valid_r[rd_index];
    assign rd_dirty = dirty_r[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : dcache_if.slave; pipeline request/load data/stalls and the
//                memory line transaction (mem_req/mem_we/mem_addr/mem_wline
//                out, mem_rline/mem_ack in)
// A miss is detected in IDLE; a dirty victim is written back in EVICT, then
// the line is read in FILL. The held request completes on return to IDLE.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    dcache_if.slave  bus
);

    state_e               state_r;
    logic                 mem_req_r;
    logic                 mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [LINE_W-1:0]    mem_wline_r;
    logic                 evict_r;
    logic [INDEX_W-1:0]   miss_idx_r;
    logic [TAG_W-1:0]     miss_tag_r;

    logic [OFFSET_W-1:0]  off_s;
    logic [INDEX_W-1:0]   idx_s;
    logic [TAG_W-1:0]     tag_s;
    logic [TAG_W-1:0]     rd_tag_s;
    logic [LINE_W-1:0]    rd_line_s;
    logic                 rd_valid_s;
    logic                 rd_dirty_s;
    logic [WORD_W-1:0]    rd_word_s;
    logic                 hit_s;
    logic                 miss_s;
    logic [WORD_W-1:0]    rdata_s;
    wr_op_e               wr_op_s;
    logic [INDEX_W-1:0]   wr_index_s;

    assign off_s = bus.req_addr[OFFSET_W + 1:2];
    assign idx_s = bus.req_addr[OFFSET_W + 2 +: INDEX_W];
    assign tag_s = bus.req_addr[ADDR_W - 1 -: TAG_W];

    dcache_line_store u_store (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (idx_s),
        .rd_tag    (rd_tag_s),
        .rd_line   (rd_line_s),
        .rd_valid  (rd_valid_s),
        .rd_dirty  (rd_dirty_s),
        .wr_op     (wr_op_s),
        .wr_index  (wr_index_s),
        .wr_offset (off_s),
        .wr_word   (bus.req_wdata),
        .wr_line   (bus.mem_rline),
        .wr_tag    (miss_tag_r)
    );

    // Hit detection and load data selection.
    always_comb begin
        rd_word_s = rd_line_s[int'(off_s) * WORD_W +: WORD_W];
        hit_s     = bus.req_valid && rd_valid_s && (rd_tag_s == tag_s);
        miss_s    = bus.req_valid && !hit_s;
        if (hit_s) begin
            rdata_s = rd_word_s;
        end else begin
            rdata_s = {WORD_W{1'b0}};
        end
    end

    // Line-store write requests; transactions target the index latched at the miss.
    always_comb begin
        wr_op_s    = WR_NONE;
        wr_index_s = idx_s;
        case (state_r)
            ST_IDLE: begin
                if (hit_s && bus.req_write) begin
                    wr_op_s = WR_WORD;
                end else begin
                    wr_op_s = WR_NONE;
                end
            end
            ST_EVICT: begin
                wr_index_s = miss_idx_r;
                if (bus.mem_ack) begin
                    wr_op_s = WR_CLEAN;
                end else begin
                    wr_op_s = WR_NONE;
                end
            end
            ST_FILL: begin
                wr_index_s = miss_idx_r;
                if (bus.mem_ack) begin
                    wr_op_s = WR_LINE;
                end else begin
                    wr_op_s = WR_NONE;
                end
            end
            default: wr_op_s = WR_NONE;
        endcase
    end

    // Controller FSM with registered memory-interface outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wline_r <= {LINE_W{1'b0}};
            evict_r     <= 1'b0;
            miss_idx_r  <= {INDEX_W{1'b0}};
            miss_tag_r  <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_s) begin
                        miss_idx_r <= idx_s;
                        miss_tag_r <= tag_s;
                        mem_req_r  <= 1'b1;
                        if (rd_valid_s && rd_dirty_s) begin
                            state_r     <= ST_EVICT;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= line_addr(rd_tag_s, idx_s);
                            mem_wline_r <= rd_line_s;
                            evict_r     <= 1'b1;
                        end else begin
                            state_r     <= ST_FILL;
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= line_addr(tag_s, idx_s);
                            mem_wline_r <= {LINE_W{1'b0}};
                            evict_r     <= 1'b0;
                        end
                    end else begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                    end
                end
                ST_EVICT: begin
                    // mem_req stays high across the hand-over to the refill.
                    if (bus.mem_ack) begin
                        state_r     <= ST_FILL;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= line_addr(miss_tag_r, miss_idx_r);
                        mem_wline_r <= {LINE_W{1'b0}};
                        evict_r     <= 1'b0;
                    end else begin
                        state_r <= ST_EVICT;
                    end
                end
                ST_FILL: begin
                    if (bus.mem_ack) begin
                        state_r    <= ST_IDLE;
                        mem_req_r  <= 1'b0;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {ADDR_W{1'b0}};
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_req_r  <= 1'b0;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= {ADDR_W{1'b0}};
                    evict_r    <= 1'b0;
                end
            endcase
        end
    end

    // Stall and load data are gated by reset so every output is 0 while it is held.
    assign bus.d_cache_miss = reset && ((state_r != ST_IDLE) || miss_s);
    assign bus.rdata        = reset ? rdata_s : {WORD_W{1'b0}};
    assign bus.enable_write_from_cache_to_memory = evict_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wline = mem_wline_r;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl. Inputs change 1 ns after the rising
// edge; outputs are checked on the falling edge.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    dcache_if bus ();

    dcache_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b0) begin miscompares++; $display("FAIL reset_miss got %b want 0", bus.d_cache_miss); end
        vectors++; if (bus.enable_write_from_cache_to_memory !== 1'b0) begin miscompares++; $display("FAIL reset_evict got %b want 0", bus.enable_write_from_cache_to_memory); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
        vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        step();
        reset = 1'b1;
    endtask

    task automatic test_refill();
        step();
        req(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b1) begin miscompares++; $display("FAIL refill_miss_same_cycle got %b want 1", bus.d_cache_miss); end
        step();
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL refill_req got req=%b we=%b want req=1 we=0", bus.mem_req, bus.mem_we); end
        vectors++; if (bus.mem_addr !== 32'h40) begin miscompares++; $display("FAIL refill_addr got %h want 00000040", bus.mem_addr); end
        step();
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 32'h40 || bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL refill_hold got addr=%h req=%b want 00000040/1", bus.mem_addr, bus.mem_req); end
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rline = {32'h4, 32'h3, 32'h2, 32'h1};
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b1) begin miscompares++; $display("FAIL refill_ack_cycle_miss got %b want 1", bus.d_cache_miss); end
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b0 || bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL refill_done got miss=%b req=%b want 0/0", bus.d_cache_miss, bus.mem_req); end
        vectors++; if (bus.rdata !== 32'h1) begin miscompares++; $display("FAIL refill_rdata got %h want 00000001", bus.rdata); end
    endtask

    task automatic test_store_hit();
        step();
        req(1'b1, 1'b1, 32'h44, 32'hDEADBEEF);
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b0 || bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL store_hit_stall got miss=%b req=%b want 0/0", bus.d_cache_miss, bus.mem_req); end
        step();
        req(1'b1, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rdata !== 32'hDEADBEEF || bus.d_cache_miss !== 1'b0) begin miscompares++; $display("FAIL store_hit_readback got %h miss=%b want deadbeef/0", bus.rdata, bus.d_cache_miss); end
        step();
        req(1'b1, 1'b0, 32'h4C, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rdata !== 32'h4) begin miscompares++; $display("FAIL word3_rdata got %h want 00000004", bus.rdata); end
    endtask

    task automatic test_dirty_evict();
        step();
        req(1'b1, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b1) begin miscompares++; $display("FAIL evict_miss got %b want 1", bus.d_cache_miss); end
        step();
        @(negedge clk);
        vectors++; if (bus.enable_write_from_cache_to_memory !== 1'b1 || bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL evict_flags got ewcm=%b we=%b want 1/1", bus.enable_write_from_cache_to_memory, bus.mem_we); end
        vectors++; if (bus.mem_addr !== 32'h40) begin miscompares++; $display("FAIL evict_addr got %h want 00000040", bus.mem_addr); end
        vectors++; if (bus.mem_wline !== {32'h4, 32'h3, 32'hDEADBEEF, 32'h1}) begin miscompares++; $display("FAIL evict_wline got %h want 00000004_00000003_deadbeef_00000001", bus.mem_wline); end
        step();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.enable_write_from_cache_to_memory !== 1'b0) begin miscompares++; $display("FAIL evict_to_fill got req=%b we=%b ewcm=%b want 1/0/0", bus.mem_req, bus.mem_we, bus.enable_write_from_cache_to_memory); end
        vectors++; if (bus.mem_addr !== 32'h80) begin miscompares++; $display("FAIL fill_after_evict_addr got %h want 00000080", bus.mem_addr); end
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rline = {32'h80C, 32'h808, 32'h804, 32'h800};
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        vectors++; if (bus.rdata !== 32'h800 || bus.d_cache_miss !== 1'b0) begin miscompares++; $display("FAIL evict_final_rdata got %h miss=%b want 00000800/0", bus.rdata, bus.d_cache_miss); end
    endtask

    task automatic test_clean_miss();
        step();
        req(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b1) begin miscompares++; $display("FAIL clean_miss got %b want 1", bus.d_cache_miss); end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            vectors++; if (bus.enable_write_from_cache_to_memory !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h10) begin miscompares++; $display("FAIL clean_fill_%0d got ewcm=%b we=%b addr=%h want 0/0/00000010", i, bus.enable_write_from_cache_to_memory, bus.mem_we, bus.mem_addr); end
        end
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rline = {32'h101C, 32'h1018, 32'h1014, 32'h1010};
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        vectors++; if (bus.rdata !== 32'h1010 || bus.enable_write_from_cache_to_memory !== 1'b0) begin miscompares++; $display("FAIL clean_rdata got %h ewcm=%b want 00001010/0", bus.rdata, bus.enable_write_from_cache_to_memory); end
    endtask

    task automatic test_store_miss();
        step();
        req(1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b1) begin miscompares++; $display("FAIL store_miss got %b want 1", bus.d_cache_miss); end
        step();
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 32'h20 || bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL store_miss_fill got addr=%h we=%b want 00000020/0", bus.mem_addr, bus.mem_we); end
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rline = {32'h2C, 32'h28, 32'h24, 32'h20};
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b0 || bus.rdata !== 32'h24) begin miscompares++; $display("FAIL store_miss_hit got miss=%b rdata=%h want 0/00000024", bus.d_cache_miss, bus.rdata); end
        step();
        req(1'b1, 1'b0, 32'h24, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL pending_store got %h want cafef00d", bus.rdata); end
        step();
        req(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rdata !== 32'h20) begin miscompares++; $display("FAIL store_line_word0 got %h want 00000020", bus.rdata); end
    endtask

    task automatic test_reset_mid_fill();
        step();
        req(1'b1, 1'b0, 32'h90, 32'h0);
        step();
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h90) begin miscompares++; $display("FAIL pre_reset_fill got req=%b addr=%h want 1/00000090", bus.mem_req, bus.mem_addr); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (bus.mem_req !== 1'b0 || bus.d_cache_miss !== 1'b0 || bus.enable_write_from_cache_to_memory !== 1'b0) begin miscompares++; $display("FAIL async_reset_drop got req=%b miss=%b ewcm=%b want 0/0/0", bus.mem_req, bus.d_cache_miss, bus.enable_write_from_cache_to_memory); end
        vectors++; if (bus.mem_addr !== 32'h0 || bus.rdata !== 32'h0) begin miscompares++; $display("FAIL async_reset_bus got addr=%h rdata=%h want 0/0", bus.mem_addr, bus.rdata); end
        step();
        req(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        // Index 2 held a dirty line before reset; it must now refill without eviction.
        req(1'b1, 1'b0, 32'h60, 32'h0);
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b1) begin miscompares++; $display("FAIL post_reset_miss got %b want 1", bus.d_cache_miss); end
        step();
        @(negedge clk);
        vectors++; if (bus.mem_we !== 1'b0 || bus.enable_write_from_cache_to_memory !== 1'b0 || bus.mem_addr !== 32'h60) begin miscompares++; $display("FAIL post_reset_no_evict got we=%b ewcm=%b addr=%h want 0/0/00000060", bus.mem_we, bus.enable_write_from_cache_to_memory, bus.mem_addr); end
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rline = {32'h60C, 32'h608, 32'h604, 32'h600};
        step();
        bus.mem_ack = 1'b0;
        req(1'b1, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        vectors++; if (bus.d_cache_miss !== 1'b1) begin miscompares++; $display("FAIL post_reset_0x44_miss got %b want 1", bus.d_cache_miss); end
        #1;
        req(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        vectors++; if (bus.d_cache_miss !== 1'b1) begin miscompares++; $display("FAIL post_reset_0x80_miss got %b want 1", bus.d_cache_miss); end
        req(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL withdrawn_req got mem_req=%b want 0", bus.mem_req); end
    endtask

    task automatic test_idle_quiet();
        for (int i = 0; i < 10; i++) begin
            step();
            req(1'b0, 1'(i % 2), $urandom, $urandom);
            bus.mem_ack = (i == 4) ? 1'b1 : 1'b0;
            @(negedge clk);
            vectors++; if (bus.d_cache_miss !== 1'b0 || bus.mem_req !== 1'b0 || bus.rdata !== 32'h0) begin miscompares++; $display("FAIL idle_%0d got miss=%b req=%b rdata=%h want 0/0/0", i, bus.d_cache_miss, bus.mem_req, bus.rdata); end
        end
        step();
        bus.mem_ack = 1'b0;
        req(1'b1, 1'b0, 32'h64, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rdata !== 32'h604 || bus.d_cache_miss !== 1'b0 || bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL after_spurious_ack got rdata=%h miss=%b req=%b want 00000604/0/0", bus.rdata, bus.d_cache_miss, bus.mem_req); end
        step();
        req(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rline = {LINE_W{1'b0}};
        req(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_refill();
        test_store_hit();
        test_dirty_evict();
        test_clean_miss();
        test_store_miss();
        test_reset_mid_fill();
        test_idle_quiet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache controller for the memory stage. It serves word loads and stores from the pipeline and runs the refill and eviction transactions to main memory. It also generates the two memory-stage stall sources, d_cache_miss and enable_write_from_cache_to_memory, that the pipeline stall/bubble logic consumes.

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, data word width
LINES, 4, number of cache lines (power of two)
WORDS_PER_LINE, 4, words per line (power of two); line width LINE_W = WORD_W*WORDS_PER_LINE

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  memory-stage access present
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address; bits [1:0] ignored (word accesses only)
req_wdata  in  WORD_W  store data
rdata  out  WORD_W  load data; valid only when req_valid and hit
d_cache_miss  out  1  stall source: refill pending or in progress
enable_write_from_cache_to_memory  out  1  stall source: dirty eviction in progress
mem_req  out  1  memory transaction request
mem_we  out  1  1 = line write (eviction), 0 = line read (refill)
mem_addr  out  ADDR_W  line-aligned address
mem_wline  out  LINE_W  eviction data
mem_rline  in  LINE_W  refill data, sampled when mem_ack = 1
mem_ack  in  1  one-cycle pulse that completes the current transaction

Behaviour:
- Address split: offset = addr[OFFSET_W+1:2], index = next INDEX_W bits, tag = remaining upper bits. Word 0 sits at mem_rline/mem_wline[WORD_W-1:0].
- Reset (reset = 0, asynchronous): state IDLE, all valid and dirty bits 0, and every output 0. Data and tag arrays are not reset. Reset mid-transaction aborts it; mem_req falls without waiting for a clock edge.
- hit = req_valid && valid[index] && tag[index] == req tag. rdata = the addressed word on a hit, otherwise 0. The output is combinational.
- IDLE:
  - Hit load: no stall.
  - Hit store: the word and dirty[index] = 1 are written at the clock edge; no stall.
  - Miss (req_valid && !hit): d_cache_miss = 1 combinationally in the same cycle.
  - On a miss, if valid[index] && dirty[index], go to EVICT; otherwise go to FILL.
  - req_valid = 0: nothing happens; all outputs 0.
- EVICT:
  - Drives mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 0}, mem_wline = victim line.
  - enable_write_from_cache_to_memory = 1; d_cache_miss = 1.
  - On mem_ack: dirty[index] = 0, go to FILL.
- FILL:
  - Drives mem_req = 1, mem_we = 0, mem_addr = {req tag, index, 0}; d_cache_miss = 1.
  - On mem_ack: write the line, tag, valid = 1, dirty = 0, then go to IDLE.
  - The ack cycle still shows d_cache_miss = 1.
- Back in IDLE the held request hits and completes, including a pending store.
- Miss penalty = (EVICT cycles) + (FILL cycles) + 1.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wline stay stable until mem_ack.
  - EVICT to FILL keeps mem_req high while mem_we and mem_addr change; each ack ends exactly one transaction.
  - mem_ack while mem_req = 0 is ignored.
- The pipeline holds req_* stable while either stall output is high. If req_valid drops mid-miss, the current transaction still completes and the line is installed.
- mem_ack arriving in the same cycle as the FSM enters a state applies only to the transaction then driven; one ack per transaction.

Decomposition:
- Shared package/include dcache_pkg:
  - state encoding (IDLE, EVICT, FILL)
  - derived widths OFFSET_W = log2(WORDS_PER_LINE), INDEX_W = log2(LINES), TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2, LINE_W
- One sub-module, dcache_line_store:
  - holds the tag, data, valid and dirty arrays, with asynchronous active-low clear of valid and dirty
  - provides a combinational read port and a single write port (word write or full-line write)
- dcache_ctrl holds the FSM, the hit logic and the memory interface.

Test Plan:
1. After reset, load 0x40 -> d_cache_miss = 1 in the same cycle, mem_req = 1, mem_we = 0, mem_addr = 0x40. Ack 3 cycles later with mem_rline words {0x4, 0x3, 0x2, 0x1} (word3..word0) -> the next cycle gives d_cache_miss = 0 and rdata = 0x1.
2. Store 0xDEADBEEF to 0x44, which hits -> no mem_req. Then load 0x44 -> rdata = 0xDEADBEEF with no stall.
3. Load 0x80 (same index, new tag, dirty victim):
   - EVICT shows enable_write_from_cache_to_memory = 1, mem_we = 1, mem_addr = 0x40, mem_wline word1 = 0xDEADBEEF.
   - After ack, FILL shows mem_addr = 0x80 with mem_req still high.
   - After the second ack, rdata is correct.
4. Clean miss on 0x10 (index 1) -> goes directly to FILL and enable_write_from_cache_to_memory never asserts.
5. Assert reset in the middle of FILL -> mem_req and both stall outputs drop immediately. A later load of 0x44 misses, because the valid bits were cleared.
6. req_valid = 0 with any req_addr for 10 cycles -> d_cache_miss = 0, mem_req = 0, rdata = 0. A spurious mem_ack pulse leaves the state unchanged.
